// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and helpers for the direct-mapped write-through data cache
package dcache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int a_width, input int sets);
        return a_width - $clog2(sets) - 2;
    endfunction

    // Lanes with be set take new_word, the rest keep old_word
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] w;
        w = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                w[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - CPU request/response and data-memory signals of the data cache
interface data_cache_if #(
    parameter int A_WIDTH = 28
);
    logic               req_valid;
    logic               req_we;
    logic [A_WIDTH-1:0] req_addr;
    logic [3:0]         req_be;
    logic [31:0]        req_wd;
    logic [31:0]        rd_data;
    logic               stall;

    logic [A_WIDTH-1:0] mem_a;
    logic               mem_we;
    logic [31:0]        mem_wd;
    logic [31:0]        mem_rd;

    // master: CPU plus memory side of the world; slave: the cache itself
    modport master (
        output req_valid, req_we, req_addr, req_be, req_wd,
        input  rd_data, stall,
        input  mem_a, mem_we, mem_wd,
        output mem_rd
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wd,
        output rd_data, stall,
        output mem_a, mem_we, mem_wd,
        input  mem_rd
    );

endinterface

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/data/valid storage, one async read port and one write port
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int TAG_W = 20,
    localparam int IW   = index_w(SETS)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [IW-1:0]    rd_index,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_word,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_index,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_word
);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags  [SETS];
    logic [31:0]      words [SETS];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until valid is set, so no reset
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            words[wr_index] <= wr_word;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_word  = words[rd_index];

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped, write-through, one-word-line data cache with hit/miss counters
module data_cache
    import dcache_pkg::*;
#(
    parameter int A_WIDTH = 28,
    parameter int SETS    = 64
) (
    input  logic          CLK,
    input  logic          RST_N,
    data_cache_if.slave   bus,
    output logic [31:0]   hit_cnt,
    output logic [31:0]   miss_cnt
);

    localparam int IW = index_w(SETS);
    localparam int TW = tag_w(A_WIDTH, SETS);

    state_t state, next_state;
    logic   retry;

    logic [IW-1:0] index;
    logic [TW-1:0] tag;
    logic          line_valid;
    logic [TW-1:0] line_tag;
    logic [31:0]   line_word;
    logic          hit;
    logic [31:0]   merged;

    logic          stall_c, mem_we_c, wr_en_c;
    logic [31:0]   mem_wd_c, wr_word_c;
    logic          hit_inc, miss_inc;

    assign index  = bus.req_addr[IW+1:2];
    assign tag    = bus.req_addr[A_WIDTH-1:IW+2];
    assign hit    = line_valid && (line_tag == tag);
    assign merged = byte_merge(line_word, bus.req_wd, bus.req_be);

    dcache_array #(
        .SETS  (SETS),
        .TAG_W (TW)
    ) u_array (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .rd_index (index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_word  (line_word),
        .wr_en    (wr_en_c & RST_N),
        .wr_index (index),
        .wr_tag   (tag),
        .wr_word  (wr_word_c)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            retry <= 1'b0;
        end else begin
            state <= next_state;
            retry <= (state == FILL);
        end
    end

    always_comb begin
        next_state = state;
        stall_c    = 1'b0;
        mem_we_c   = 1'b0;
        mem_wd_c   = bus.req_wd;
        wr_en_c    = 1'b0;
        wr_word_c  = bus.req_wd;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!bus.req_we) begin
                        if (hit) begin
                            hit_inc = 1'b1;
                        end else begin
                            miss_inc   = 1'b1;
                            stall_c    = 1'b1;
                            next_state = FILL;
                        end
                    end else if (bus.req_be == 4'h0) begin
                        hit_inc  = hit;
                        miss_inc = !hit;
                    end else if (hit) begin
                        hit_inc   = 1'b1;
                        wr_en_c   = 1'b1;
                        wr_word_c = merged;
                        mem_we_c  = 1'b1;
                        mem_wd_c  = merged;
                    end else if (bus.req_be == 4'hF) begin
                        // Full-word store needs no old data: allocate directly
                        miss_inc = 1'b1;
                        wr_en_c  = 1'b1;
                        mem_we_c = 1'b1;
                    end else begin
                        miss_inc   = 1'b1;
                        stall_c    = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                stall_c    = 1'b1;
                wr_en_c    = 1'b1;
                wr_word_c  = bus.mem_rd;
                next_state = IDLE;
            end
        endcase
    end

    // The lookup right after a fill is the same access retried; it is not counted again
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (!retry) begin
            if (hit_inc && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_inc && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign bus.stall   = stall_c & RST_N;
    assign bus.mem_we  = mem_we_c & RST_N;
    assign bus.mem_wd  = mem_wd_c;
    assign bus.mem_a   = bus.req_addr & ~{{(A_WIDTH-2){1'b0}}, 2'b11};
    assign bus.rd_data = line_word;

endmodule
